// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART controller: decodes the data/status words and buffers RX and TX bytes in FIFOs.
// It also paces async_transmitter with a start/busy handshake, so CPU accesses never stall on the line.
module uart_mmio_bridge #(
  parameter logic [31:0] DATA_ADDR     = 32'hBFD003F8,
  parameter logic [31:0] STAT_ADDR     = 32'hBFD003FC,
  parameter int          RX_DEPTH_LOG2 = 4,
  parameter int          TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        hit,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_clear,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        rx_overflow
);

  localparam int RXD = 1 << RX_DEPTH_LOG2;
  localparam int TXD = 1 << TX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] RX_ONE = 1;
  localparam logic [TX_DEPTH_LOG2:0] TX_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND} tx_state_t;

  logic [7:0]             r_rx_mem [RXD];
  logic [7:0]             r_tx_mem [TXD];
  logic [RX_DEPTH_LOG2:0] r_rx_wptr, r_rx_rptr;
  logic [TX_DEPTH_LOG2:0] r_tx_wptr, r_tx_rptr;
  logic [31:0]            r_rdata;
  logic                   r_ack, r_rx_ovf, r_tx_start, r_start_cnt, r_tx_avail;
  logic [7:0]             r_tx_data;
  tx_state_t              r_state, w_next;

  logic w_hit_data, w_hit_stat, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_rx_pop, w_rx_push, w_tx_pop, w_tx_push;
  logic w_unused;

  assign w_unused   = &{1'b0, wdata[31:8]};
  assign w_hit_data = req && (addr == DATA_ADDR);
  assign w_hit_stat = req && (addr == STAT_ADDR);
  assign hit        = w_hit_data || w_hit_stat;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[RX_DEPTH_LOG2] != r_rx_rptr[RX_DEPTH_LOG2]) &&
                      (r_rx_wptr[RX_DEPTH_LOG2-1:0] == r_rx_rptr[RX_DEPTH_LOG2-1:0]);
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[TX_DEPTH_LOG2] != r_tx_rptr[TX_DEPTH_LOG2]) &&
                      (r_tx_wptr[TX_DEPTH_LOG2-1:0] == r_tx_rptr[TX_DEPTH_LOG2-1:0]);

  // A same-cycle pop frees the slot, so a push into a full FIFO is accepted alongside it
  assign w_rx_pop  = w_hit_data && !we && !w_rx_empty;
  assign w_rx_push = rx_ready && (!w_rx_full || w_rx_pop);
  assign w_tx_push = w_hit_data && we && (!w_tx_full || w_tx_pop);

  assign rx_clear    = rx_ready;
  assign rdata       = r_rdata;
  assign ack         = r_ack;
  assign rx_overflow = r_rx_ovf;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr[TX_DEPTH_LOG2-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack     <= 1'b0;
      r_rdata   <= 32'd0;
      r_rx_ovf  <= 1'b0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      r_ack <= hit;
      if (w_hit_stat && !we)
        r_rdata <= {30'd0, !w_rx_empty, !w_tx_full};
      else if (w_hit_data && !we)
        r_rdata <= w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rptr[RX_DEPTH_LOG2-1:0]]};
      if (rx_ready && w_rx_full && !w_rx_pop)
        r_rx_ovf <= 1'b1;
      else if (w_hit_stat && we)
        r_rx_ovf <= 1'b0;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_ONE;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_ONE;
    end
  end

  // r_tx_avail delays FIFO occupancy by one cycle, giving the two-cycle ack-to-start latency
  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tx_avail && !w_tx_empty && !tx_busy) begin
          w_tx_pop = 1'b1;
          w_next   = S_START;
        end
      end
      S_START: if (tx_busy || r_start_cnt) w_next = S_SEND;
      S_SEND:  if (!tx_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'd0;
      r_start_cnt <= 1'b0;
      r_tx_avail  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tx_start  <= w_tx_pop;
      r_start_cnt <= (r_state == S_START) && (w_next == S_START);
      r_tx_avail  <= !w_tx_empty;
      if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rptr[TX_DEPTH_LOG2-1:0]];
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: bus reads/writes, RX capture/overflow, TX pacing and reset.
module tb_uart_mmio_bridge;

  localparam logic [31:0] DADDR = 32'hBFD003F8;
  localparam logic [31:0] SADDR = 32'hBFD003FC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack, hit;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_clear;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        rx_overflow;

  logic        hold_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        auto_en = 1'b0;
  int          busy_len = 3;
  int          n_total = 0, n_bad = 0;
  int          n_start = 0;
  logic [7:0]  tx_q[$];

  assign tx_busy = hold_busy | model_busy;

  uart_mmio_bridge dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .hit(hit), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_clear(rx_clear), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      tx_q.push_back(tx_data);
    end
  end

  // Transmitter model: busy rises after each start pulse and lasts busy_len cycles
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && tx_start) begin
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick(1);
    req = 1'b0; we = 1'b0;
    check("ack", {31'd0, ack}, 32'd1);
    rd = rdata;
  endtask

  task automatic check_drain(input string tag, input int base, input int cnt, input logic [7:0] first);
    logic [31:0] got;
    check({tag, "_count"}, tx_q.size() - base, cnt);
    for (int i = 0; i < cnt; i++) begin
      got = (base + i < tx_q.size()) ? {24'd0, tx_q[base + i]} : 32'hDEAD;
      check(tag, got, {24'd0, first + 8'(i)});
    end
  endtask

  initial begin
    logic [31:0] rd;
    int s0, b0;
    bit seen;

    tick(3);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_txs", {31'd0, tx_start}, 32'd0);
    check("rst_txd", {24'd0, tx_data}, 32'd0);
    check("rst_ovf", {31'd0, rx_overflow}, 32'd0);
    check("rst_rxclr", {31'd0, rx_clear}, 32'd0);
    reset = 1'b0;
    tick(1);

    bus(1'b0, SADDR, 32'd0, rd);
    check("stat_reset", rd, 32'h1);
    tick(1);
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    check("rdata_hold", rdata, 32'h1);

    req = 1'b1; addr = 32'hBFD003F0; #1;
    check("hit_miss", {31'd0, hit}, 32'd0);
    tick(1);
    req = 1'b0;
    check("miss_no_ack", {31'd0, ack}, 32'd0);

    // Single byte: start pulse two cycles after the write ack
    auto_en = 1'b1; busy_len = 100;
    s0 = n_start;
    bus(1'b1, DADDR, 32'h141, rd);
    tick(1);
    check("lat_early", {31'd0, tx_start}, 32'd0);
    tick(1);
    check("lat_start", {31'd0, tx_start}, 32'd1);
    check("lat_data", {24'd0, tx_data}, 32'h41);
    tick(120);
    check("one_start", n_start - s0, 32'd1);

    // RX single byte
    rx_data = 8'h5A; rx_ready = 1'b1; #1;
    check("rx_clear", {31'd0, rx_clear}, 32'd1);
    tick(1);
    rx_ready = 1'b0;
    bus(1'b0, SADDR, 32'd0, rd); check("stat_rx", rd, 32'h3);
    bus(1'b0, DADDR, 32'd0, rd); check("rx_5a", rd, 32'h5A);
    bus(1'b0, SADDR, 32'd0, rd); check("stat_rx_empty", rd, 32'h1);

    // RX overflow on the 17th byte
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'(i); rx_ready = 1'b1;
      if (i == 16) check("ovf_before", {31'd0, rx_overflow}, 32'd0);
      tick(1);
    end
    rx_ready = 1'b0;
    check("ovf_set", {31'd0, rx_overflow}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, DADDR, 32'd0, rd);
      check("rx_order", rd, 32'(i));
    end
    bus(1'b0, DADDR, 32'd0, rd); check("rx_empty_read", rd, 32'd0);
    bus(1'b1, SADDR, 32'd0, rd);
    tick(1);
    check("ovf_clear", {31'd0, rx_overflow}, 32'd0);

    // TX fill while busy held, extra bytes dropped, then drain
    auto_en = 1'b1; busy_len = 3; hold_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus(1'b1, DADDR, 32'(i), rd);
      if (i == 15) begin
        bus(1'b0, SADDR, 32'd0, rd); check("tx_full_stat", rd, 32'h0);
      end
    end
    b0 = tx_q.size();
    hold_busy = 1'b0;
    tick(300);
    check_drain("tx_fill1", b0, 16, 8'h00);

    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) bus(1'b1, DADDR, 32'h80 + 32'(i), rd);
    bus(1'b0, SADDR, 32'd0, rd); check("tx_full_stat2", rd, 32'h0);
    b0 = tx_q.size();
    hold_busy = 1'b0;
    tick(300);
    check_drain("tx_fill2", b0, 16, 8'h80);

    // RX full: pop and push in the same cycle keep the count at 16
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h20 + 8'(i); rx_ready = 1'b1;
      tick(1);
    end
    req = 1'b1; we = 1'b0; addr = DADDR; rx_data = 8'h99; rx_ready = 1'b1;
    tick(1);
    req = 1'b0; rx_ready = 1'b0;
    check("same_ack", {31'd0, ack}, 32'd1);
    check("same_rdata", rdata, 32'h20);
    check("same_ovf", {31'd0, rx_overflow}, 32'd0);
    rx_data = 8'h77; rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("still_full", {31'd0, rx_overflow}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      bus(1'b0, DADDR, 32'd0, rd);
      check("same_order", rd, 32'h20 + 32'(i));
    end
    bus(1'b0, DADDR, 32'd0, rd); check("same_new", rd, 32'h99);
    bus(1'b0, SADDR, 32'd0, rd); check("same_empty", rd, 32'h1);
    bus(1'b1, SADDR, 32'd0, rd);

    // Reset asserted while a byte is being sent
    auto_en = 1'b0;
    bus(1'b1, DADDR, 32'h55, rd);
    bus(1'b1, DADDR, 32'h66, rd);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (tx_start) seen = 1'b1;
    end
    check("rst_start_seen", {31'd0, seen}, 32'd1);
    hold_busy = 1'b1;
    tick(3);
    reset = 1'b1; #1;
    check("mid_rst_txs", {31'd0, tx_start}, 32'd0);
    check("mid_rst_txd", {24'd0, tx_data}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    hold_busy = 1'b0;
    s0 = n_start;
    tick(15);
    check("no_resend", n_start - s0, 32'd0);
    bus(1'b0, SADDR, 32'd0, rd); check("stat_after_rst", rd, 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
Memory-mapped serial port controller between the CPU data-memory bus and the on-board async_receiver/async_transmitter pair. It decodes the UART data and status words in the 0xBFD003F8/0xBFD003FC window. It buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO. It sequences async_transmitter through a start/busy handshake, so the CPU never stalls on the 9600-baud line.

Parameters:
DATA_ADDR, 32'hBFD003F8, byte address of UART data register
STAT_ADDR, 32'hBFD003FC, byte address of UART status register
RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries)
TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries)

Ports:
clk  in  1  system clock, same clock as CPU_top and the UART modules (50 MHz)
reset  in  1  asynchronous, active-high reset
req  in  1  CPU bus request, valid one cycle per access
we  in  1  1 = write, 0 = read
addr  in  32  CPU byte address
wdata  in  32  write data; only wdata[7:0] is used
rdata  out  32  read data
ack  out  1  one-cycle acknowledge
hit  out  1  combinational: req && addr is DATA_ADDR or STAT_ADDR
rx_ready  in  1  async_receiver RxD_data_ready
rx_data  in  8  async_receiver RxD_data
rx_clear  out  1  async_receiver RxD_clear
tx_busy  in  1  async_transmitter TxD_busy
tx_start  out  1  async_transmitter TxD_start
tx_data  out  8  async_transmitter TxD_data
rx_overflow  out  1  sticky flag: byte dropped because RX FIFO was full

Behaviour:
- Reset values (asynchronous): rdata=0, ack=0, rx_clear=0, tx_start=0, tx_data=0, rx_overflow=0, both FIFOs empty, TX FSM in IDLE.
- Bus timing: a request with hit=1 is acked on the next clock edge. ack stays high for exactly one cycle. rdata is valid in the same cycle as ack and holds its value until the next read ack. Requests with hit=0 are ignored (no ack).
- Read of STAT_ADDR: rdata = {30'b0, rx_nonempty, tx_notfull}. Bit0 is TX writable and bit1 is RX data available, both sampled in the request cycle. No side effects.
- Read of DATA_ADDR:
  - RX FIFO non-empty: rdata = {24'b0, head byte} and the FIFO pops.
  - RX FIFO empty: rdata = 0, no pop.
- Write of DATA_ADDR:
  - TX FIFO not full: wdata[7:0] is pushed.
  - TX FIFO full: the byte is discarded silently and the access is still acked.
- Write of STAT_ADDR: any write clears rx_overflow. Nothing else changes.
- RX capture:
  - rx_ready=1: rx_clear=1 combinationally in the same cycle, and rx_data is pushed at that edge.
  - RX FIFO full at that edge: the byte is dropped and rx_overflow is set.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This holds even when the FIFO is full, because the pop frees the slot first.
- TX FIFO with simultaneous push and pop: same rule as RX.
- FIFOs: circular buffers with (DEPTH_LOG2+1)-bit pointers. Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal. Pointers wrap naturally.
- TX FSM (registered):
  - IDLE: if TX FIFO non-empty and tx_busy=0, load tx_data from the head, pop, assert tx_start for one cycle, and go to START.
  - START: wait for tx_busy=1, then go to SEND. If tx_busy is still 0 after 2 cycles, go to SEND anyway (guards against a missed busy edge).
  - SEND: when tx_busy=0, go to IDLE.
  - Back-to-back bytes: at least 1 idle cycle between a busy fall and the next tx_start.
- Reset asserted mid-transfer: the FSM returns to IDLE and the FIFOs are flushed. A byte already on the line is finished by async_transmitter; it is not resent.
- Latency: from the CPU write ack to tx_start is 2 cycles when the FIFO was empty and the line was idle.

Test Plan:
- Reset, then read STAT_ADDR -> ack next cycle, rdata=32'h00000001; rx_overflow=0, tx_start=0.
- Write 0x41 to DATA_ADDR with tx_busy idle -> tx_start pulses 2 cycles after ack with tx_data=8'h41. A model that holds busy high for 100 cycles sees no further tx_start.
- Pulse rx_ready with rx_data=0x5A, then read STAT_ADDR -> rdata=32'h3. Read DATA_ADDR -> rdata=32'h5A. STAT then reads 32'h1.
- Push 17 RX bytes 0x00..0x10 with no reads -> rx_overflow=1, and 16 reads return 0x00..0x0F in order. Write STAT_ADDR -> rx_overflow=0.
- Write 20 bytes while tx_busy is held high -> STAT bit0=0 after 16 writes and the extra 4 bytes are dropped. On release, exactly 16 tx_start pulses carry bytes 0..15 in order. Pointers wrap after a second fill.
- rx_ready pulse in the same cycle as a DATA read of the full FIFO -> pop and push both occur, count stays 16, rx_overflow stays 0. Reset asserted mid-SEND -> FSM in IDLE, STAT=1 after release.
